ifetch_queue: RTL and testbench

Instruction fetch front end that feeds the Core pipeline's decode stage. It owns the fetch PC, issues in-order word requests to instruction memory, and buffers returned instructions with their PCs in a small prefetch queue. A decode-side redirect (branch, jump or trap) flushes the queue and discards stale in-flight responses. Credit-based issue guarantees that a response always has a free queue slot.

---
 rtl/ifetch_queue.sv | 144 ++++++++++++++
 tb/tb_ifetch_queue.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: owns the fetch PC, issues in-order imem word requests and
// buffers returned instructions with their PCs for decode.
module ifetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int unsigned   AW      = $clog2(DEPTH);
    localparam int unsigned   CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   stale_q, stale_d;
    logic [AW-1:0]   q_wr_q, q_wr_d;
    logic [AW-1:0]   q_rd_q, q_rd_d;
    logic [AW-1:0]   f_wr_q, f_wr_d;
    logic [AW-1:0]   f_rd_q, f_rd_d;

    logic [XLEN-1:0] q_data_q [DEPTH];
    logic [XLEN-1:0] q_pc_q   [DEPTH];
    logic [XLEN-1:0] f_pc_q   [DEPTH];

    logic [CW-1:0] used;
    logic          accept;
    logic          resp;
    logic          drop;
    logic          enq;
    logic          deq;
    logic          has_head;
    logic          unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc[1:0];

    // Credits include stale requests, so a drained slot is never double-booked.
    assign used           = count_q + outstanding_q;
    assign imem_req_valid = (state_q == S_FETCH) && (used < DEPTH_C);
    assign imem_req_addr  = pc_q;

    assign has_head   = (count_q != '0);
    assign inst_valid = has_head && !redirect_valid;
    assign inst_data  = has_head ? q_data_q[q_rd_q] : '0;
    assign inst_pc    = has_head ? q_pc_q[q_rd_q] : '0;

    assign accept = imem_req_valid && imem_req_ready;
    assign resp   = imem_resp_valid;
    assign drop   = resp && ((stale_q != '0) || redirect_valid);
    assign enq    = resp && !drop;
    assign deq    = inst_valid && inst_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = accept ? pc_q + XLEN'(4) : pc_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(resp);
        stale_d       = stale_q;
        count_d       = count_q + CW'(enq) - CW'(deq);
        q_wr_d        = q_wr_q + AW'(enq);
        q_rd_d        = q_rd_q + AW'(deq);
        f_wr_d        = f_wr_q + AW'(accept);
        f_rd_d        = f_rd_q + AW'(resp);

        if (resp && (stale_q != '0)) begin
            stale_d = stale_q - CW'(1);
        end

        unique case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: state_d = S_FETCH;
            S_DRAIN: state_d = (stale_d == '0) ? S_FETCH : S_DRAIN;
            default: state_d = S_BOOT;
        endcase

        // Everything still in flight after this cycle belongs to the old path.
        if (redirect_valid) begin
            pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
            count_d = '0;
            q_wr_d  = '0;
            q_rd_d  = '0;
            stale_d = outstanding_d;
            if (state_q != S_BOOT) begin
                state_d = (outstanding_d != '0) ? S_DRAIN : S_FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            stale_q       <= '0;
            q_wr_q        <= '0;
            q_rd_q        <= '0;
            f_wr_q        <= '0;
            f_rd_q        <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
            q_wr_q        <= q_wr_d;
            q_rd_q        <= q_rd_d;
            f_wr_q        <= f_wr_d;
            f_rd_q        <= f_rd_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers/counters.
    always_ff @(posedge clk) begin
        if (accept) begin
            f_pc_q[f_wr_q] <= pc_q;
        end
        if (enq) begin
            q_data_q[q_wr_q] <= imem_resp_data;
            q_pc_q[q_wr_q]   <= f_pc_q[f_rd_q];
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: boot, streaming, backpressure,
// redirect draining, redirect-cycle collisions, reset and PC wrap.
module tb_ifetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    logic        w_req_valid;
    logic        w_req_ready;
    logic [31:0] w_req_addr;
    logic        w_resp_valid;
    logic [31:0] w_resp_data;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic        w_inst_valid;
    logic        w_inst_ready;
    logic [31:0] w_inst_data;
    logic [31:0] w_inst_pc;

    ifetch_queue #(
        .XLEN(32), .RESET_PC(32'h8000_0000), .DEPTH(DEPTH)
    ) u_dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    ifetch_queue #(
        .XLEN(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)
    ) u_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_req_addr(w_req_addr),
        .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .inst_valid(w_inst_valid), .inst_ready(w_inst_ready),
        .inst_data(w_inst_data), .inst_pc(w_inst_pc)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_acc    = 0;
    int          n_deq    = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          viol     = 0;
    bit          mem_rdy  = 1'b0;
    logic        last_iv;
    logic        last_acc;
    logic        last_rsp;
    logic [31:0] exp_pc;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle from a negedge to the next; memory model answers in order.
    task automatic step();
        logic        acc;
        logic        deq;
        logic        rsp;
        logic [31:0] a;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (pend_addr.size() != 0) begin
            if (pend_due[0] <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem(pend_addr[0]);
            end
        end
        imem_req_ready = mem_rdy;
        #1;
        acc      = imem_req_valid && imem_req_ready;
        a        = imem_req_addr;
        rsp      = imem_resp_valid;
        deq      = inst_valid && inst_ready;
        last_iv  = inst_valid;
        last_acc = acc;
        last_rsp = rsp;
        if (deq) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst_data", inst_data, mem(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_deq++;
        end
        if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
        @(posedge clk);
        if (rsp) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (acc) begin
            pend_addr.push_back(a);
            pend_due.push_back(cyc + lat);
            n_acc++;
        end
        if (pend_addr.size() > DEPTH) viol++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_boot();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("boot_req_valid", 32'(imem_req_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("fetch_req_valid", 32'(imem_req_valid), 32'd1);
        chk("fetch_addr", imem_req_addr, 32'h8000_0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int d;
        int n;
        reset            = 1'b0;
        imem_req_ready   = 1'b0;
        imem_resp_valid  = 1'b0;
        imem_resp_data   = '0;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        inst_ready       = 1'b0;
        w_req_ready      = 1'b0;
        w_resp_valid     = 1'b0;
        w_resp_data      = '0;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = '0;
        w_inst_ready     = 1'b0;
        exp_pc           = 32'h8000_0000;

        #12;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h8000_0000);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        do_boot();

        // streaming, latency 1
        mem_rdy    = 1'b1;
        inst_ready = 1'b1;
        lat        = 1;
        repeat (4) step();
        d = n_deq;
        repeat (8) step();
        chk("stream_rate", 32'(n_deq - d), 32'd8);

        // backpressure
        inst_ready = 1'b0;
        repeat (8) step();
        chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
        chk("bp_inflight", 32'(n_acc - n_deq), 32'd4);
        inst_ready = 1'b1;
        d = n_deq;
        repeat (8) step();
        chk("bp_resume_deq", 32'(n_deq - d), 32'd8);
        chk("bp_resume_inflight", 32'(n_acc - n_deq), 32'd3);

        // redirect with two requests outstanding
        mem_rdy = 1'b0;
        repeat (8) step();
        chk("drain_idle", 32'(n_acc - n_deq), 32'd0);
        lat     = 4;
        mem_rdy = 1'b1;
        repeat (2) step();
        mem_rdy        = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0103;
        step();
        redirect_valid = 1'b0;
        chk("drain_req_valid", 32'(imem_req_valid), 32'd0);
        mem_rdy = 1'b1;
        n = 0;
        while (!imem_req_valid && n < 20) begin
            step();
            n++;
        end
        chk("drain_len", 32'(n), 32'd3);
        chk("redir_addr", imem_req_addr, 32'h8000_0100);
        lat = 1;
        d   = n_deq;
        repeat (6) step();
        chk("redir_deq", 32'(n_deq - d), 32'd4);

        // response and accept coincide with the redirect
        mem_rdy = 1'b0;
        repeat (6) step();
        mem_rdy    = 1'b1;
        inst_ready = 1'b0;
        repeat (2) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        step();
        redirect_valid = 1'b0;
        chk("sim_acc", 32'(last_acc), 32'd1);
        chk("sim_resp", 32'(last_rsp), 32'd1);
        chk("sim_inst_valid", 32'(last_iv), 32'd0);
        chk("sim_req_valid", 32'(imem_req_valid), 32'd0);
        n = 0;
        while (!imem_req_valid && n < 20) begin
            step();
            n++;
        end
        chk("sim_drain_len", 32'(n), 32'd1);
        chk("sim_addr", imem_req_addr, 32'h8000_0200);
        inst_ready = 1'b1;
        repeat (6) step();

        // redirect with nothing in flight restarts on the next cycle
        mem_rdy = 1'b0;
        repeat (6) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0400;
        step();
        redirect_valid = 1'b0;
        chk("nostale_valid", 32'(imem_req_valid), 32'd1);
        chk("nostale_addr", imem_req_addr, 32'h8000_0400);
        mem_rdy = 1'b1;
        repeat (6) step();

        // asynchronous reset mid-stream
        chk("pre_rst_iv", 32'(inst_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("arst_req_addr", imem_req_addr, 32'h8000_0000);
        chk("arst_inst_valid", 32'(inst_valid), 32'd0);
        chk("arst_inst_data", inst_data, 32'd0);
        chk("arst_inst_pc", inst_pc, 32'd0);
        pend_addr.delete();
        pend_due.delete();
        exp_pc = 32'h8000_0000;
        repeat (2) @(posedge clk);
        do_boot();
        d = n_deq;
        repeat (6) step();
        chk("post_rst_deq", 32'(n_deq - d), 32'd4);

        // PC wrap on the second instance
        chk("wrap_addr0", w_req_addr, 32'hFFFF_FFFC);
        w_req_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("wrap_addr1", w_req_addr, 32'h0000_0000);
        w_resp_valid = 1'b1;
        w_resp_data  = mem(32'hFFFF_FFFC);
        @(posedge clk);
        @(negedge clk);
        w_req_ready  = 1'b0;
        w_resp_data  = mem(32'h0000_0000);
        w_inst_ready = 1'b1;
        #1;
        chk("wrap_iv", 32'(w_inst_valid), 32'd1);
        chk("wrap_pc0", w_inst_pc, 32'hFFFF_FFFC);
        chk("wrap_data0", w_inst_data, mem(32'hFFFF_FFFC));
        @(posedge clk);
        @(negedge clk);
        w_resp_valid = 1'b0;
        #1;
        chk("wrap_pc1", w_inst_pc, 32'h0000_0000);
        chk("wrap_data1", w_inst_data, mem(32'h0000_0000));

        chk("credit", 32'(viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
